reg_wb_arbiter: RTL

- Write-side master for the ID-stage register file; drives its we/waddr/wd write port.
- Merges two sources into the single write port:
  - single-cycle pipeline writeback (WB stage);
  - long-latency RV32M results (div/rem unit), received over a valid/ready handshake.
- Keeps a per-register pending scoreboard. The ID-stage hazard logic uses it to stall readers of registers that still await an M result.

---
 rtl/reg_wb_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: register-file write-port master.
// It merges pipeline writebacks and queued RV32M results.
// It also keeps the pending-register scoreboard.
// Ports:
//   clk, rst (async, active-low).
//   wb_*     : pipeline writeback request.
//   md_*     : M-unit result handshake.
//   issue_*  : long-latency op dispatch.
//   raddr1/2 : ID read ports. hazard flags a pending source.
//   busy_mask: per-register pending bits.
//   wb_hold  : advisory bubble request.
//   we/waddr/wd: registered register-file write port.
module reg_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int RADDR_W      = 5,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wb_valid,
   input  logic [RADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               md_valid,
   output logic               md_ready,
   input  logic [RADDR_W-1:0] md_rd,
   input  logic [XLEN-1:0]    md_data,
   input  logic               issue_valid,
   input  logic [RADDR_W-1:0] issue_rd,
   input  logic [RADDR_W-1:0] raddr1,
   input  logic [RADDR_W-1:0] raddr2,
   output logic               hazard,
   output logic [31:0]        busy_mask,
   output logic               wb_hold,
   output logic               we,
   output logic [RADDR_W-1:0] waddr,
   output logic [XLEN-1:0]    wd
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

   logic [RADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
   logic [RADDR_W-1:0] fifo_rd_d   [FIFO_DEPTH];
   logic [XLEN-1:0]    fifo_data_q [FIFO_DEPTH];
   logic [XLEN-1:0]    fifo_data_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic               we_q, we_d;
   logic [RADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]    wd_q, wd_d;
   logic               src_md_q, src_md_d;

   logic [31:0]        busy_q, busy_d;
   logic [ST_W-1:0]    starve_q, starve_d;
   logic               hold_q, hold_d;
   logic               pop_q;

   logic wb_go;
   logic fifo_empty;
   logic pop;
   logic push;

   function automatic logic [PTR_W-1:0] ptr_inc(
      input logic [PTR_W-1:0] p
   );
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready comes from the registered count only: no pop look-ahead.
   assign md_ready   = (count_q < CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign wb_go      = wb_valid && (wb_rd != '0);
   assign pop        = !wb_go && !fifo_empty;
   // x0 results finish the handshake but are dropped.
   assign push       = md_valid && md_ready && (md_rd != '0);

   always_comb begin
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) begin
         fifo_rd_d[wr_ptr_q]   = md_rd;
         fifo_data_d[wr_ptr_q] = md_data;
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wd_d     = wd_q;
      src_md_d = 1'b0;
      unique case (1'b1)
         wb_go: begin
            we_d    = 1'b1;
            waddr_d = wb_rd;
            wd_d    = wb_data;
         end
         pop: begin
            we_d     = 1'b1;
            waddr_d  = fifo_rd_q[rd_ptr_q];
            wd_d     = fifo_data_q[rd_ptr_q];
            src_md_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Clear at the commit edge of an M write; a same-edge issue wins.
   always_comb begin
      busy_d = busy_q;
      if (we_q && src_md_q) begin
         busy_d[waddr_q] = 1'b0;
      end
      if (issue_valid && (issue_rd != '0)) begin
         busy_d[issue_rd] = 1'b1;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (starve_q != ST_W'(STARVE_LIMIT)) begin
         starve_d = starve_q + ST_W'(1);
      end
   end

   // Hold drops one edge after the pop that relieved the head.
   always_comb begin
      hold_d = hold_q;
      if (pop_q) begin
         hold_d = 1'b0;
      end else if (starve_d == ST_W'(STARVE_LIMIT)) begin
         hold_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_rd_q[i]   <= '0;
            fifo_data_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wd_q     <= '0;
         src_md_q <= 1'b0;
         busy_q   <= '0;
         starve_q <= '0;
         hold_q   <= 1'b0;
         pop_q    <= 1'b0;
      end else begin
         fifo_rd_q   <= fifo_rd_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wd_q        <= wd_d;
         src_md_q    <= src_md_d;
         busy_q      <= busy_d;
         starve_q    <= starve_d;
         hold_q      <= hold_d;
         pop_q       <= pop;
      end
   end

   assign hazard = ((raddr1 != '0) && busy_q[raddr1]) ||
                   ((raddr2 != '0) && busy_q[raddr2]);

   assign busy_mask = busy_q;
   assign wb_hold   = hold_q;
   assign we        = we_q;
   assign waddr     = waddr_q;
   assign wd        = wd_q;

endmodule
